song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 The block SHALL have parameter AW, default 6, meaning ROM address width; the song holds up to 2**AW entries.
REQ-002 The block SHALL have parameter TICK, default 1200000, meaning clk cycles per duration unit (100 ms at 12 MHz).
REQ-003 The block SHALL have parameter GAP, default 120000, meaning silent clk cycles inserted after each note; 0 disables the gap.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins playback from address 0; ignored while busy.
REQ-007 The block SHALL have port stop, input, 1 bit: aborts playback.
REQ-008 The block SHALL have port loop, input, 1 bit: when high at end of song, playback restarts at address 0.
REQ-009 The block SHALL have port rom_addr, output, AW bits: address to the external synchronous ROM.
REQ-010 The block SHALL have port rom_data, input, 20 bits: ROM word; [19:16] is the duration in TICK units, [15:0] is the note divisor; rom_data is valid one clock after rom_addr.
REQ-011 The block SHALL have port note, output, 16 bits: registered divisor to the note generator; 0 means silence.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal end of song.

Function
REQ-014 The block SHALL implement the states IDLE, FETCH, LOAD, PLAY and GAP.
REQ-015 In IDLE, the block SHALL hold note=0, busy=0 and rom_addr=0; start=1 with stop=0 SHALL move to FETCH.
REQ-016 FETCH SHALL last exactly 1 cycle (ROM latency) and then move to LOAD.
REQ-017 In LOAD, a duration field of 0 SHALL be treated as the end-of-song marker; otherwise the block SHALL capture the divisor into note, load the duration counter, clear the tick counter and move to PLAY.
REQ-018 Note timing: note SHALL change to the captured divisor on the 2nd clock edge after the edge that samples start or enters FETCH.
REQ-019 In PLAY, note SHALL hold the divisor for exactly duration*TICK cycles.
REQ-019a The tick counter SHALL count 0..TICK-1 and then decrement the duration counter.
REQ-019b On the final tick, the block SHALL go to GAP if GAP>0, else to FETCH with rom_addr+1.
REQ-020 In GAP, note SHALL be 0 for exactly GAP cycles, then the block SHALL go to FETCH with rom_addr+1.
REQ-021 End of song SHALL occur on an end-of-song marker, or on completion of the entry at address 2**AW-1; rom_addr SHALL wrap to 0 in both cases.
REQ-022 At end of song with loop=1, the block SHALL go to FETCH at address 0 with no done pulse; loop SHALL be sampled only at that moment.
REQ-023 At end of song with loop=0, the block SHALL go to IDLE with done=1 for exactly one cycle.
REQ-024 If the end-of-song marker is at address 0, the block SHALL go to IDLE with a done pulse regardless of loop, so an empty song never spins.
REQ-025 stop=1 in any non-IDLE state SHALL, at the next edge, force IDLE with note=0, rom_addr=0 and no done pulse.
REQ-026 stop SHALL have priority over start, and start together with stop in IDLE SHALL leave the block in IDLE.
REQ-027 The tick counter SHALL be $clog2(TICK) bits wide, the gap counter $clog2(GAP) bits (minimum 1), and the duration counter 4 bits; no counter SHALL overflow.

Reset
REQ-028 rstn=0 SHALL asynchronously force IDLE, note=0, busy=0, done=0, rom_addr=0 and all counters to 0, including mid-PLAY.
REQ-029 After rstn is released, the block SHALL remain in IDLE until start.

Verification (TICK=4, GAP=2, AW=6 unless stated)
REQ-030 Single play: ROM {0:(2,100),1:(1,200),2:(0,-)}, loop=0, start pulse -> note=100 for 8 cycles, 0 for 2, 200 for 4, then 0 through the next FETCH/LOAD; then done=1 for 1 cycle, busy=0, rom_addr=0.
REQ-031 Loop: same ROM with loop=1 -> the 100/200 pattern repeats at least twice, done stays 0, busy stays 1.
REQ-032 Stop: stop pulse in the 3rd cycle of note=100 -> next cycle note=0, busy=0, done=0; a later start replays from address 0.
REQ-033 Async reset: rstn low mid-PLAY with no clock edge -> note=0, busy=0, rom_addr=0 immediately.
REQ-034 Empty song: ROM {0:(0,-)}, loop=1, start -> done=1 exactly 2 edges after start sampled, busy=0 after that, no refetch.
REQ-035 Wrap: AW=2, all 4 entries (1,k+1), loop=0 -> notes 1,2,3,4 each for 4 cycles, then done, rom_addr=0.

Source files
------------

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song stored in an external synchronous ROM and drives
// a note divisor to a tone generator.
//
// Each ROM word is {duration[3:0], divisor[15:0]}. A duration of 0 marks the end
// of the song. Each note plays for duration*TICK clocks. It is followed by GAP
// silent clocks, and then the next address is fetched.
//
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   start     begin playback at address 0 (ignored while busy)
//   stop      abort playback, return to idle without a done pulse
//   loop      sampled at end of song: restart instead of finishing
//   rom_addr  ROM address (ROM data is valid one clock later)
//   rom_data  ROM word {duration, divisor}
//   note      registered divisor, 0 = silence
//   busy      high whenever not idle
//   done      one-cycle pulse at normal end of song
module song_sequencer #(
  parameter int unsigned AW   = 6,
  parameter int unsigned TICK = 1200000,
  parameter int unsigned GAP  = 120000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [AW-1:0] rom_addr,
  input  logic [19:0]   rom_data,
  output logic [15:0]   note,
  output logic          busy,
  output logic          done
);

  localparam int unsigned TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [TW-1:0] TickLast = TW'(TICK - 1);
  localparam logic [GW-1:0] GapLast  = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [AW-1:0] AddrLast = '1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay,
    StGap
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   note_q, note_d;
  logic [3:0]    dur_q, dur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;

  // Per-cycle events raised by the state decode and resolved below it.
  logic entry_done;  // current entry fully played (note plus gap)
  logic song_end;    // end of song reached
  logic empty_song;  // end marker found at address 0

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    note_d     = note_q;
    dur_d      = dur_q;
    tick_d     = tick_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    entry_done = 1'b0;
    song_end   = 1'b0;
    empty_song = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StFetch;
        end
      end

      // ROM latency: data for addr_q appears in StLoad.
      StFetch: begin
        state_d = StLoad;
      end

      StLoad: begin
        if (rom_data[19:16] == 4'd0) begin
          song_end   = 1'b1;
          empty_song = (addr_q == '0);
        end else begin
          note_d  = rom_data[15:0];
          dur_d   = rom_data[19:16];
          tick_d  = '0;
          state_d = StPlay;
        end
      end

      StPlay: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          dur_d  = dur_q - 4'd1;
          if (dur_q == 4'd1) begin
            note_d = '0;
            if (GAP != 0) begin
              gap_d   = '0;
              state_d = StGap;
            end else begin
              entry_done = 1'b1;
            end
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          gap_d      = '0;
          entry_done = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Advance to the next entry, or treat completion of the last address as end of song.
    if (entry_done) begin
      if (addr_q == AddrLast) begin
        song_end = 1'b1;
      end else begin
        addr_d  = addr_q + AW'(1);
        state_d = StFetch;
      end
    end

    // An empty song never loops, so it cannot spin on the marker.
    if (song_end) begin
      addr_d = '0;
      note_d = '0;
      if (loop && !empty_song) begin
        state_d = StFetch;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    // Abort overrides everything, including an end-of-song done pulse.
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      addr_d  = '0;
      note_d  = '0;
      dur_d   = '0;
      tick_d  = '0;
      gap_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign note     = note_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer. The expected per-cycle output trace of a playback is built from the
// song contents (fetch, load, duration*TICK note cycles, GAP silent cycles per entry) and checked
// against the DUT every cycle. Stop, async reset and idle behaviour use literal expectations.
module tb_song_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        stop_s = 1'b0;
  logic        loop_s = 1'b0;

  logic [5:0]  addr_a;
  logic [19:0] data_a = '0;
  logic [15:0] note_a;
  logic        busy_a, done_a;

  logic [1:0]  addr_b;
  logic [19:0] data_b = '0;
  logic [15:0] note_b;
  logic        busy_b, done_b;

  logic [19:0] rom_a [64];
  logic [19:0] rom_b [4];

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [15:0] note;
    logic        busy;
    logic        done;
    logic [5:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  logic run_chk = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  song_sequencer #(.AW(6), .TICK(TICK), .GAP(GAP)) u_dut_a (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start_a),
    .stop     (stop_s),
    .loop     (loop_s),
    .rom_addr (addr_a),
    .rom_data (data_a),
    .note     (note_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  song_sequencer #(.AW(2), .TICK(TICK), .GAP(GAP)) u_dut_b (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start_b),
    .stop     (stop_s),
    .loop     (loop_s),
    .rom_addr (addr_b),
    .rom_data (data_b),
    .note     (note_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  // Synchronous ROMs with one cycle of latency.
  always @(posedge clk) begin
    data_a <= rom_a[addr_a];
    data_b <= rom_b[addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void push(input logic [15:0] n, input logic b, input logic d, input int a);
    exp_t e;
    e.note = n;
    e.busy = b;
    e.done = d;
    e.addr = 6'(a);
    exp_q.push_back(e);
  endfunction

  // Expected trace, one entry per cycle starting with the cycle after start is sampled.
  task automatic build(input bit use_b, input bit lp, input int cap);
    int a;
    int last;
    logic [19:0] w;
    a = 0;
    last = use_b ? 3 : 63;
    while (exp_q.size() < cap) begin
      w = use_b ? rom_b[a] : rom_a[a];
      push(16'd0, 1'b1, 1'b0, a);  // fetch
      push(16'd0, 1'b1, 1'b0, a);  // load
      if (w[19:16] == 4'd0) begin
        if (lp && a != 0) begin
          a = 0;
          continue;
        end
        push(16'd0, 1'b0, 1'b1, 0);
        repeat (3) push(16'd0, 1'b0, 1'b0, 0);
        break;
      end
      repeat (int'(w[19:16]) * TICK) push(w[15:0], 1'b1, 1'b0, a);
      repeat (GAP) push(16'd0, 1'b1, 1'b0, a);
      if (a == last) begin
        if (lp) begin
          a = 0;
          continue;
        end
        push(16'd0, 1'b0, 1'b1, 0);
        repeat (3) push(16'd0, 1'b0, 1'b0, 0);
        break;
      end
      a++;
    end
    while (exp_q.size() > cap) void'(exp_q.pop_back());
  endtask

  // Compare process: checks the selected DUT against the trace each cycle, 1 time unit after
  // the rising edge.
  always begin
    @(posedge clk);
    #1;
    if (run_chk && exp_q.size() != 0) begin
      cur_e = exp_q.pop_front();
      chk("trace_note", sel ? note_b : note_a, cur_e.note);
      chk("trace_busy", sel ? busy_b : busy_a, cur_e.busy);
      chk("trace_done", sel ? done_b : done_a, cur_e.done);
      chk("trace_addr", sel ? {4'd0, addr_b} : addr_a, cur_e.addr);
    end
  end

  // Pulse start for one cycle and let the compare process drain the trace. The task returns on a
  // falling edge.
  task automatic run_play(input bit use_b, input bit lp);
    sel = use_b;
    @(negedge clk);
    loop_s = lp;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    run_chk = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("trace_drained", exp_q.size(), 0);
    exp_q.delete();
    run_chk = 1'b0;
  endtask

  task automatic chk_idle_a(input string name);
    chk({name, "_note"}, note_a, 0);
    chk({name, "_busy"}, busy_a, 0);
    chk({name, "_done"}, done_a, 0);
    chk({name, "_addr"}, addr_a, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_a[i] = '0;
    rom_a[0] = {4'd2, 16'd100};
    rom_a[1] = {4'd1, 16'd200};
    for (int k = 0; k < 4; k++) rom_b[k] = {4'd1, 16'(k + 1)};

    // Reset state.
    #1;
    chk_idle_a("reset");
    chk("reset_busy_b", busy_b, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_a("post_reset");

    // Single play; the trace shape is pinned with hand-computed values.
    build(1'b0, 1'b0, 1000);
    chk("model_len", exp_q.size(), 26);
    chk("model_first_note", exp_q[2].note, 100);
    chk("model_last_100", exp_q[9].note, 100);
    chk("model_gap", exp_q[10].note, 0);
    chk("model_200", exp_q[14].note, 200);
    chk("model_done_idx", exp_q[22].done, 1);
    run_play(1'b0, 1'b0);

    // Loop: two full passes plus some extra cycles (one pass is 22 cycles), then stop.
    build(1'b0, 1'b1, 50);
    chk("model_loop_refetch", exp_q[22].addr, 0);
    chk("model_loop_note", exp_q[24].note, 100);
    run_play(1'b0, 1'b1);
    stop_s = 1'b1;
    @(negedge clk);
    stop_s = 1'b0;
    chk_idle_a("loop_stop");

    // Stop during the third cycle of note 100, then replay from address 0.
    build(1'b0, 1'b0, 5);
    run_play(1'b0, 1'b0);
    chk("pre_stop_note", note_a, 100);
    stop_s = 1'b1;
    @(negedge clk);
    stop_s = 1'b0;
    chk_idle_a("stop");
    build(1'b0, 1'b0, 1000);
    run_play(1'b0, 1'b0);

    // Asynchronous reset while playing, with no clock edge in between.
    build(1'b0, 1'b0, 6);
    run_play(1'b0, 1'b0);
    chk("pre_rst_note", note_a, 100);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_note", note_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_addr", addr_a, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_a("arst_hold");

    // Start together with stop in idle has no effect.
    start_a = 1'b1;
    stop_s = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    stop_s = 1'b0;
    chk("startstop_busy", busy_a, 0);
    @(negedge clk);
    chk("startstop_busy2", busy_a, 0);

    // Empty song with loop=1: done two edges after start, then no further fetch.
    rom_a[0] = '0;
    build(1'b0, 1'b1, 1000);
    chk("model_empty_len", exp_q.size(), 6);
    chk("model_empty_done", exp_q[2].done, 1);
    run_play(1'b0, 1'b1);
    chk("empty_busy_after", busy_a, 0);

    // Address wrap on the two-bit instance.
    loop_s = 1'b0;
    build(1'b1, 1'b0, 1000);
    chk("model_wrap_len", exp_q.size(), 36);
    chk("model_wrap_note4", exp_q[26].note, 4);
    run_play(1'b1, 1'b0);
    chk("wrap_addr", addr_b, 0);
    chk("wrap_busy", busy_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
